// File: rtl/indication_word_serializer_pkg.sv
// indication_word_serializer_pkg: shared header field layout, widths and serializer state type
package indication_word_serializer_pkg;
  localparam int MSG_W    = 128;
  localparam int WORD_W   = 32;
  localparam int LEN_LSB  = 0;
  localparam int LEN_W    = 16;
  localparam int METH_LSB = 16;
  localparam int METH_W   = 16;
  typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/indication_word_serializer_msg_fifo.sv
// msg_fifo: DEPTH x 128-bit register FIFO; ports CLK, nRST (sync active-low), enq/enq_data, deq, head, full, count
module msg_fifo
  import indication_word_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq,
  input  logic [MSG_W-1:0]         enq_data,
  input  logic                     deq,
  output logic [MSG_W-1:0]         head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [MSG_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_enq, do_deq;
  assign full   = count == (PW+1)'(DEPTH);
  assign head   = mem[rp];
  assign do_enq = enq & ~full;
  assign do_deq = deq & (count != '0);
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[wp] <= enq_data;
        wp      <= wp + PW'(1);
      end
      if (do_deq) rp <= rp + PW'(1);
      count <= count + (PW+1)'(do_enq) - (PW+1)'(do_deq);
    end
  end
endmodule

// File: rtl/indication_word_serializer.sv
// indication_word_serializer: buffers 128-bit indication messages and streams them out as length-limited 32-bit words
module indication_word_serializer
  import indication_word_serializer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MAXLEN = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               pipe_enq__ENA,
  input  logic [MSG_W-1:0]   pipe_enq_v,
  output logic               pipe_enq__RDY,
  output logic               word_enq__ENA,
  output logic [WORD_W-1:0]  word_enq_v,
  output logic               word_enq_last,
  input  logic               word_enq__RDY,
  output logic [15:0]        dropCount
);
  localparam int IW = $clog2(MAXLEN);
  logic [MSG_W-1:0] head;
  logic full, drop, xfer, last, deq;
  logic [$clog2(DEPTH):0] count;
  logic [LEN_W-1:0] len;
  logic [IW:0] eff;
  logic [IW-1:0] idx;
  state_e state;
  msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .nRST(nRST), .enq(pipe_enq__ENA), .enq_data(pipe_enq_v),
    .deq(deq), .head(head), .full(full), .count(count)
  );
  always_comb begin
    len   = head[LEN_LSB +: LEN_W];
    eff   = (len > LEN_W'(MAXLEN)) ? (IW+1)'(MAXLEN) : len[IW:0];
    drop  = (count != '0) && (len == '0);
    state = ((count != '0) && !drop) ? SEND : IDLE;
    last  = (state == SEND) && ({1'b0, idx} == eff - (IW+1)'(1));
    xfer  = (state == SEND) && word_enq__RDY;
    deq   = drop | (xfer & last);
  end
  assign pipe_enq__RDY = ~full;
  assign word_enq__ENA = xfer;
  assign word_enq_last = last;
  assign word_enq_v    = (state == SEND) ? head[idx*WORD_W +: WORD_W] : '0;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      idx       <= '0;
      dropCount <= '0;
    end else begin
      if (xfer) idx <= last ? '0 : idx + IW'(1);
      if (drop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    end
  end
endmodule
